// File: rtl/vga_pixel_fetch_pkg.sv
// Shared definitions for the VGA pixel-fetch stage: display geometry,
// framebuffer scaling, sync polarity, RGB332 field layout, swap FSM encoding
// and small helpers for texel addressing and colour expansion.
package vga_pixel_fetch_pkg;

    // Display geometry and framebuffer scaling
    localparam int unsigned H_RES       = 640;
    localparam int unsigned V_RES       = 480;
    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned FB_W        = H_RES >> SCALE_SHIFT;
    localparam int unsigned FB_H        = V_RES >> SCALE_SHIFT;

    // Bus widths
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TEXEL_W = ADDR_W - 1;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned CHAN_W  = 8;

    // Syncs are active low; blank_n low means blanked
    localparam logic SYNC_IDLE   = 1'b1;
    localparam logic BLANK_IDLE  = 1'b0;

    // RGB332 field positions (MSB and width of each channel)
    localparam int unsigned R_MSB = 7;
    localparam int unsigned R_W   = 3;
    localparam int unsigned G_MSB = 4;
    localparam int unsigned G_W   = 3;
    localparam int unsigned B_MSB = 1;
    localparam int unsigned B_W   = 2;

    typedef enum logic [1:0] {
        SWAP_IDLE    = 2'd0,
        SWAP_PENDING = 2'd1,
        SWAP_ACK     = 2'd2
    } swap_state_t;

    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic blank_n;
    } sync_bus_t;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb888_t;

    localparam sync_bus_t SYNC_BUS_IDLE = '{h_sync: SYNC_IDLE, v_sync: SYNC_IDLE, blank_n: BLANK_IDLE};

    // Linear texel index of a screen position; truncated to the texel field
    function automatic logic [TEXEL_W-1:0] texel_index(input logic [POS_W-1:0] x,
                                                       input logic [POS_W-1:0] y);
        return TEXEL_W'((32'(y) >> SCALE_SHIFT) * FB_W + (32'(x) >> SCALE_SHIFT));
    endfunction

    // Expand RGB332 to 8 bits per channel by bit replication
    function automatic rgb888_t rgb332_expand(input logic [PIX_W-1:0] c);
        rgb888_t o;
        o.r = {c[R_MSB -: R_W], c[R_MSB -: R_W], c[R_MSB -: 2]};
        o.g = {c[G_MSB -: G_W], c[G_MSB -: G_W], c[G_MSB -: 2]};
        o.b = {c[B_MSB -: B_W], c[B_MSB -: B_W], c[B_MSB -: B_W], c[B_MSB -: B_W]};
        return o;
    endfunction

endpackage

// File: rtl/vga_swap_ctrl.sv
// Front/back buffer swap controller. Accepts a level swap request from the
// GPU and flips the displayed buffer only on a vsync falling edge, then holds
// a four-phase acknowledge until the request drops.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   pix_en     - pixel tick; the vsync history advances only on it
//   v_sync_in  - vsync from the timing generator (active low)
//   swap_req   - GPU swap request (level)
//   front_buf  - buffer currently displayed
//   swap_ack   - swap acknowledge (level)
module vga_swap_ctrl
    import vga_pixel_fetch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic v_sync_in,
    input  logic swap_req,
    output logic front_buf,
    output logic swap_ack
);

    swap_state_t state_q, state_d;
    logic        front_buf_q, front_buf_d;
    logic        swap_ack_q, swap_ack_d;
    logic        vs_prev_q, vs_prev_d;
    logic        vs_fall_c;

    // Falling vsync edge as seen tick-to-tick
    assign vs_fall_c = pix_en && !v_sync_in && vs_prev_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SWAP_IDLE;
            front_buf_q <= 1'b0;
            swap_ack_q  <= 1'b0;
            vs_prev_q   <= SYNC_IDLE;
        end else begin
            state_q     <= state_d;
            front_buf_q <= front_buf_d;
            swap_ack_q  <= swap_ack_d;
            vs_prev_q   <= vs_prev_d;
        end
    end

    // Next-state logic; a dropped request wins over a coincident edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            SWAP_IDLE: begin
                if (swap_req) state_d = SWAP_PENDING;
            end
            SWAP_PENDING: begin
                if (!swap_req)      state_d = SWAP_IDLE;
                else if (vs_fall_c) state_d = SWAP_ACK;
            end
            SWAP_ACK: begin
                if (!swap_req) state_d = SWAP_IDLE;
            end
            default: state_d = SWAP_IDLE;
        endcase
    end

    // Output logic; the buffer flips only on the PENDING -> ACK transition
    always_comb begin
        front_buf_d = front_buf_q;
        swap_ack_d  = (state_d == SWAP_ACK);
        vs_prev_d   = pix_en ? v_sync_in : vs_prev_q;
        if ((state_q == SWAP_PENDING) && (state_d == SWAP_ACK)) begin
            front_buf_d = !front_buf_q;
        end
    end

    assign front_buf = front_buf_q;
    assign swap_ack  = swap_ack_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel-fetch stage behind the VGA timing generator. Each pixel tick issues
// a framebuffer read for the down-scaled texel under the beam, then expands
// the returned RGB332 colour and presents it with syncs/blank delayed by two
// ticks so that colour and timing line up at the DAC.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   pix_en                      - one-clk pixel tick; pipeline advances only on it
//   pos_x, pos_y                - beam position
//   blank_n_in, h_sync_in,
//   v_sync_in                   - timing generator outputs
//   fb_rd_en, fb_rd_addr        - framebuffer read strobe / {front_buf, texel}
//   fb_rd_data                  - RGB332 texel returned by the framebuffer
//   swap_req, swap_ack          - GPU buffer-swap handshake
//   front_buf                   - buffer currently displayed
//   h_sync_out, v_sync_out,
//   blank_n_out                 - aligned timing outputs
//   vga_r, vga_g, vga_b         - DAC colour
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    input  logic              blank_n_in,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [PIX_W-1:0]  fb_rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              blank_n_out,
    output logic [CHAN_W-1:0] vga_r,
    output logic [CHAN_W-1:0] vga_g,
    output logic [CHAN_W-1:0] vga_b
);

    logic              fb_rd_en_q, fb_rd_en_d;
    logic [ADDR_W-1:0] fb_rd_addr_q, fb_rd_addr_d;
    logic              valid_q, valid_d;
    sync_bus_t         stage1_q, stage1_d;
    sync_bus_t         out_q, out_d;
    rgb888_t           rgb_q, rgb_d;

    logic              front_buf_c;
    logic              fetch_ok_c;
    logic [TEXEL_W-1:0] texel_c;

    vga_swap_ctrl u_swap_ctrl (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .v_sync_in (v_sync_in),
        .swap_req  (swap_req),
        .front_buf (front_buf_c),
        .swap_ack  (swap_ack)
    );

    // Only visible, on-screen pixels fetch; everything else is shown black
    assign fetch_ok_c = blank_n_in
                     && (pos_x < POS_W'(H_RES))
                     && (pos_y < POS_W'(V_RES));
    assign texel_c    = texel_index(pos_x, pos_y);

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_rd_en_q   <= 1'b0;
            fb_rd_addr_q <= '0;
            valid_q      <= 1'b0;
            stage1_q     <= SYNC_BUS_IDLE;
            out_q        <= SYNC_BUS_IDLE;
            rgb_q        <= '0;
        end else begin
            fb_rd_en_q   <= fb_rd_en_d;
            fb_rd_addr_q <= fb_rd_addr_d;
            valid_q      <= valid_d;
            stage1_q     <= stage1_d;
            out_q        <= out_d;
            rgb_q        <= rgb_d;
        end
    end

    // Two-stage pipeline: issue read + stage syncs, then capture colour
    always_comb begin
        fb_rd_en_d   = 1'b0;
        fb_rd_addr_d = fb_rd_addr_q;
        valid_d      = valid_q;
        stage1_d     = stage1_q;
        out_d        = out_q;
        rgb_d        = rgb_q;
        if (pix_en) begin
            fb_rd_en_d   = fetch_ok_c;
            fb_rd_addr_d = {front_buf_c, texel_c};
            valid_d      = fetch_ok_c;
            stage1_d     = '{h_sync: h_sync_in, v_sync: v_sync_in, blank_n: blank_n_in};
            out_d        = stage1_q;
            // Invalid or blanked pixels are black regardless of the RAM bus
            rgb_d        = (stage1_q.blank_n && valid_q) ? rgb332_expand(fb_rd_data) : '0;
        end
    end

    assign fb_rd_en    = fb_rd_en_q;
    assign fb_rd_addr  = fb_rd_addr_q;
    assign front_buf   = front_buf_c;
    assign h_sync_out  = out_q.h_sync;
    assign v_sync_out  = out_q.v_sync;
    assign blank_n_out = out_q.blank_n;
    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: stimulus pushes expected pixels and
// read addresses, a monitor pops and compares as the DUT presents them.
module tb_vga_pixel_fetch;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        blank_n_in;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        fb_rd_en;
    logic [15:0] fb_rd_addr;
    logic [7:0]  fb_rd_data = 8'hFF;
    logic        swap_req;
    logic        swap_ack;
    logic        front_buf;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        blank_n_out;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic [7:0]  mem [0:65535];
    exp_t        pix_q[$];
    logic [15:0] fetch_q[$];
    exp_t        cur;
    logic        exp_front, exp_ack, exp_pending, prev_vs;
    int          errors = 0;
    int          checks = 0;

    vga_pixel_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .blank_n_in  (blank_n_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .fb_rd_en    (fb_rd_en),
        .fb_rd_addr  (fb_rd_addr),
        .fb_rd_data  (fb_rd_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .front_buf   (front_buf),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .blank_n_out (blank_n_out),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer RAM model: one clk read latency
    always @(posedge clk) begin
        if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
    end

    // n-bit channel value scaled to 0..255, rounded to nearest
    function automatic logic [7:0] scale3(input int v);
        return 8'((v * 255 + 3) / 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel tick; called and returns on a falling clock edge
    task automatic do_tick(input int x, input int y, input logic bl,
                           input logic hs, input logic vs, input int gap);
        logic        ok;
        logic [15:0] addr;
        int          c;
        exp_t        e;
        pos_x      = 10'(x);
        pos_y      = 10'(y);
        blank_n_in = bl;
        h_sync_in  = hs;
        v_sync_in  = vs;
        pix_en     = 1'b1;
        ok   = bl && (x < 640) && (y < 480);
        addr = {exp_front, 15'((y / 4) * 160 + x / 4)};
        c    = ok ? int'(mem[addr]) : 0;
        e.hs = hs;
        e.vs = vs;
        e.bl = bl;
        e.r  = scale3(c / 32);
        e.g  = scale3((c / 4) % 8);
        e.b  = 8'((c % 4) * 85);
        pix_q.push_back(e);
        if (ok) fetch_q.push_back(addr);
        @(posedge clk);
        // Displayed buffer flips on a vsync falling edge only while a swap is pending
        if (exp_pending && prev_vs && !vs) begin
            exp_front   = !exp_front;
            exp_pending = 1'b0;
            exp_ack     = 1'b1;
        end
        prev_vs = vs;
        @(negedge clk);
        pix_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic idle_tick();
        do_tick(0, 0, 1'b0, 1'b1, 1'b1, 1);
    endtask

    task automatic set_req(input logic v);
        swap_req = v;
        @(posedge clk);
        if (v) begin
            if (!exp_ack) exp_pending = 1'b1;
        end else begin
            exp_pending = 1'b0;
            exp_ack     = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        exp_t e;
        rst        = 1'b1;
        pix_en     = 1'b0;
        swap_req   = 1'b0;
        pos_x      = '0;
        pos_y      = '0;
        blank_n_in = 1'b0;
        h_sync_in  = 1'b1;
        v_sync_in  = 1'b1;
        repeat (3) @(negedge clk);
        pix_q.delete();
        fetch_q.delete();
        e           = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, r: 8'd0, g: 8'd0, b: 8'd0};
        cur         = e;
        pix_q.push_back(e);
        exp_front   = 1'b0;
        exp_ack     = 1'b0;
        exp_pending = 1'b0;
        prev_vs     = 1'b1;
        rst         = 1'b0;
    endtask

    // Monitor: checks read issue, swap outputs and held pixel outputs every clk
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (fb_rd_en === 1'b1) begin
                    if (fetch_q.size() == 0) chk("fb_rd_en_spurious", 32'(fb_rd_en), 32'd0);
                    else chk("fb_rd_addr", 32'(fb_rd_addr), 32'(fetch_q.pop_front()));
                end
                chk("front_buf", 32'(front_buf), 32'(exp_front));
                chk("swap_ack", 32'(swap_ack), 32'(exp_ack));
                if (pix_en) begin
                    if (pix_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pix_queue: output with no expected pixel at %0t", $time);
                    end else begin
                        cur = pix_q.pop_front();
                    end
                end
                chk("h_sync_out", 32'(h_sync_out), 32'(cur.hs));
                chk("v_sync_out", 32'(v_sync_out), 32'(cur.vs));
                chk("blank_n_out", 32'(blank_n_out), 32'(cur.bl));
                chk("vga_r", 32'(vga_r), 32'(cur.r));
                chk("vga_g", 32'(vga_g), 32'(cur.g));
                chk("vga_b", 32'(vga_b), 32'(cur.b));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int x, y;
        logic bl;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[321]             = 8'hE0;
        mem[16'(2 * 160 + 2)] = 8'hFF;

        do_reset();
        repeat (4) idle_tick();

        // Single fetch with a known texel value
        do_tick(5, 9, 1'b1, 1'b1, 1'b1, 1);
        idle_tick();

        // One-tick vsync pulse, then a long stall
        do_tick(10, 10, 1'b1, 1'b1, 1'b0, 1);
        do_tick(11, 10, 1'b1, 1'b1, 1'b1, 10);
        do_tick(12, 10, 1'b1, 1'b1, 1'b1, 1);

        // Blanked off-screen pixel while the RAM bus still reads 0xFF
        do_tick(8, 8, 1'b1, 1'b1, 1'b1, 1);
        do_tick(700, 10, 1'b0, 1'b1, 1'b1, 1);
        do_tick(639, 479, 1'b1, 1'b0, 1'b1, 1);
        do_tick(640, 100, 1'b1, 1'b1, 1'b1, 1);
        do_tick(100, 480, 1'b1, 1'b1, 1'b1, 1);
        idle_tick();

        // Aborted swap: request for ~50 clk with no vsync edge
        set_req(1'b1);
        for (int i = 0; i < 16; i++) do_tick(i, 20, 1'b1, 1'b1, 1'b1, 2);
        set_req(1'b0);
        do_tick(0, 490, 1'b0, 1'b1, 1'b1, 1);
        do_tick(0, 490, 1'b0, 1'b1, 1'b0, 1);
        do_tick(0, 491, 1'b0, 1'b1, 1'b1, 1);

        // Completed swap at the next vsync falling edge
        set_req(1'b1);
        for (int i = 0; i < 6; i++) do_tick(20 + i, 30, 1'b1, 1'b1, 1'b1, 1);
        do_tick(0, 490, 1'b0, 1'b1, 1'b1, 1);
        do_tick(0, 490, 1'b0, 1'b1, 1'b0, 1);
        do_tick(0, 491, 1'b0, 1'b1, 1'b0, 1);
        do_tick(0, 0, 1'b1, 1'b1, 1'b1, 1);
        do_tick(1, 0, 1'b1, 1'b1, 1'b0, 1);
        do_tick(2, 0, 1'b1, 1'b1, 1'b1, 1);
        set_req(1'b0);
        repeat (3) @(negedge clk);

        // Randomised pixel stream with irregular tick spacing
        for (int i = 0; i < 300; i++) begin
            x  = int'($urandom_range(0, 799));
            y  = int'($urandom_range(0, 524));
            bl = ($urandom_range(0, 7) != 0) ? ((x < 640) && (y < 480)) : 1'($urandom);
            do_tick(x, y, bl, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                    int'($urandom_range(1, 3)));
        end

        // Reset in the middle of a handshake returns to the displayed-buffer-0 state
        set_req(1'b1);
        do_tick(3, 3, 1'b1, 1'b1, 1'b1, 1);
        do_reset();
        repeat (3) idle_tick();

        chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
        chk("pixel_queue_level", 32'(pix_q.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
